pipelined_adder_ch: RTL

Parametrised, clocked successor to the combinational delayed adder. It replaces the modelled propagation delay with a fixed STAGES-deep register pipeline. Other additions:
- valid tagging
- add/subtract mode
- global stall
- optional change-detect issue mode (a result is issued only when operands or mode change)
- wrap-around result counter

It sits between operand producers and any consumer that needs a deterministic, cycle-exact sum latency.

---
 rtl/pipelined_adder_ch_if.sv | 26 ++
 rtl/pipelined_adder_ch.sv | 115 +++++++++++
 2 files changed

// File: rtl/pipelined_adder_ch_if.sv
// Operand/result bundle for pipelined_adder_ch.
// The master side produces operands and consumes results; the slave side is the adder.
interface pipelined_adder_ch_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             en;
    logic             in_valid;
    logic             mode_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH:0]   sum;
    logic             busy;
    logic [CNT_W-1:0] result_count;

    modport master (
        output en, in_valid, mode_sub, a, b,
        input  out_valid, sum, busy, result_count
    );

    modport slave (
        input  en, in_valid, mode_sub, a, b,
        output out_valid, sum, busy, result_count
    );
endinterface

// File: rtl/pipelined_adder_ch.sv
// Fixed-latency add/subtract pipeline with valid tagging, global stall,
// optional change-detect issue and a wrapping delivered-result counter.
module pipelined_adder_ch #(
    parameter int WIDTH    = 4,
    parameter int STAGES   = 5,
    parameter int CHG_MODE = 0,
    parameter int CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipelined_adder_ch_if.slave  bus
);
    localparam int LAST = STAGES - 1;

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [WIDTH:0]    dat_q [STAGES];
    logic [WIDTH:0]    dat_d [STAGES];

    logic [WIDTH-1:0]  last_a_q;
    logic [WIDTH-1:0]  last_a_d;
    logic [WIDTH-1:0]  last_b_q;
    logic [WIDTH-1:0]  last_b_d;
    logic              last_mode_q;
    logic              last_mode_d;
    logic              first_q;
    logic              first_d;

    logic              out_valid_q;
    logic              out_valid_d;
    logic [WIDTH:0]    sum_q;
    logic [WIDTH:0]    sum_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic              changed;
    logic              issue;
    logic              exit_valid;
    logic [WIDTH:0]    result;

    assign changed = first_q
                   | (bus.a != last_a_q)
                   | (bus.b != last_b_q)
                   | (bus.mode_sub != last_mode_q);
    assign issue   = bus.en & bus.in_valid & ((CHG_MODE == 0) | changed);

    // Widened by one bit so the MSB is carry on add and borrow on subtract.
    assign result = bus.mode_sub ? ({1'b0, bus.a} - {1'b0, bus.b})
                                 : ({1'b0, bus.a} + {1'b0, bus.b});

    assign vld_d[0] = bus.en ? issue : vld_q[0];
    assign dat_d[0] = issue ? result : dat_q[0];

    generate
        for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
            assign vld_d[gi] = bus.en ? vld_q[gi-1] : vld_q[gi];
            assign dat_d[gi] = bus.en ? dat_q[gi-1] : dat_q[gi];
        end
    endgenerate

    assign exit_valid = bus.en & vld_q[LAST];

    always_comb begin
        last_a_d    = last_a_q;
        last_b_d    = last_b_q;
        last_mode_d = last_mode_q;
        first_d     = first_q;
        if (issue) begin
            last_a_d    = bus.a;
            last_b_d    = bus.b;
            last_mode_d = bus.mode_sub;
            first_d     = 1'b0;
        end
    end

    // Outputs freeze while stalled; a held out_valid is never recounted.
    always_comb begin
        out_valid_d = bus.en ? vld_q[LAST] : out_valid_q;
        sum_d       = exit_valid ? dat_q[LAST] : sum_q;
        cnt_d       = exit_valid ? (cnt_q + CNT_W'(1)) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q       <= '0;
            for (int i = 0; i < STAGES; i++) begin
                dat_q[i] <= '0;
            end
            last_a_q    <= '0;
            last_b_q    <= '0;
            last_mode_q <= 1'b0;
            first_q     <= 1'b1;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cnt_q       <= '0;
        end else begin
            vld_q       <= vld_d;
            for (int i = 0; i < STAGES; i++) begin
                dat_q[i] <= dat_d[i];
            end
            last_a_q    <= last_a_d;
            last_b_q    <= last_b_d;
            last_mode_q <= last_mode_d;
            first_q     <= first_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.sum          = sum_q;
    assign bus.busy         = (|vld_q) | out_valid_q;
    assign bus.result_count = cnt_q;
endmodule
